// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled serial input, DBIT data bits LSB-first, stop-bit check.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and a parity_err output.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [5:0]      s_cnt_q, s_cnt_d;
  logic [3:0]      n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_reg_q, b_reg_d;
  logic [DBIT-1:0] rx_data_q, rx_data_d;
  logic            done_q, done_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
`ifdef UART_RX_PARITY_EN
  logic            par_pend_q, par_pend_d;
  logic            parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      b_reg_q     <= '0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_pend_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      b_reg_q     <= b_reg_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
`ifdef UART_RX_PARITY_EN
      par_pend_q   <= par_pend_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    b_reg_d     = b_reg_q;
    rx_data_d   = rx_data_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_pend_d   = par_pend_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a line held low never re-triggers.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == 6'd7) begin
            if (!rx_sync_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == 6'd15) begin
            b_reg_d = {rx_sync_q, b_reg_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == 4'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 4'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 6'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == 6'd15) begin
            par_pend_d = (^b_reg_q) ^ rx_sync_q;
            s_cnt_d    = '0;
            state_d    = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 6'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == 6'(SB_TICK-1)) begin
            rx_data_d   = b_reg_q;
            frame_err_d = ~rx_sync_q;
            done_d      = 1'b1;
            s_cnt_d     = '0;
            state_d     = IDLE;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_pend_q;
`endif
          end else begin
            s_cnt_d = s_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data      = rx_data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (8 data bits, 1 stop bit, s_tick every clk).
// Parity step is included only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] cap_data [0:31];
  logic       cap_ferr [0:31];
  logic       cap_perr [0:31];
  int         cap_cyc  [0:31];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every high cycle of rx_done_tick is logged, so a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      if (done_cnt < 32) begin
        cap_data[done_cnt] = rx_data;
        cap_ferr[done_cnt] = frame_err;
        cap_cyc[done_cnt]  = cyc;
`ifdef UART_RX_PARITY_EN
        cap_perr[done_cnt] = parity_err;
`else
        cap_perr[done_cnt] = 1'b0;
`endif
      end
      $display("rx frame #%0d: data=%02h frame_err=%0b cyc=%0d", done_cnt, rx_data, frame_err, cyc);
      done_cnt = done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives nb bits (start bit prepended, stop bit appended), 16 clks each; assumes call just after a posedge.
  task automatic send_bits(input logic [8:0] bits, input int nb, input logic stop);
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_bits({^b, b}, 9, stop);
`else
    send_bits({1'b0, b}, 8, stop);
`endif
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base;
  int t0;
  int lat_exp;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_done", 32'(rx_done_tick), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    idle(4);

    // 1: 0xA5, latency = sampling edge + 8 + 128 + 16 ticks + 2 sync clks
    base = done_cnt;
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    idle(4);
    chk("t1_pulse_count", 32'(done_cnt - base), 32'd1);
    chk("t1_data", 32'(cap_data[base]), 32'hA5);
    chk("t1_frame_err", 32'(cap_ferr[base]), 32'h0);
`ifdef UART_RX_PARITY_EN
    lat_exp = 1 + 8 + 128 + 16 + 16 + 2;
`else
    lat_exp = 1 + 8 + 128 + 16 + 2;
`endif
    chk("t1_latency", 32'(cap_cyc[base] - t0), 32'(lat_exp));
    chk("t1_hold_data", 32'(rx_data), 32'hA5);

    // 2: 4-tick glitch rejected, then 0x3C
    base = done_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    chk("t2_glitch_no_pulse", 32'(done_cnt - base), 32'd0);
    chk("t2_glitch_data_held", 32'(rx_data), 32'hA5);
    send_byte(8'h3C, 1'b1);
    idle(4);
    chk("t2_pulse_count", 32'(done_cnt - base), 32'd1);
    chk("t2_data", 32'(cap_data[base]), 32'h3C);

    // 3: stop bit low -> frame_err, next good frame clears it
    base = done_cnt;
    send_byte(8'h55, 1'b0);
    idle(20);
    chk("t3_pulse_count", 32'(done_cnt - base), 32'd1);
    chk("t3_data", 32'(cap_data[base]), 32'h55);
    chk("t3_frame_err", 32'(cap_ferr[base]), 32'h1);
    chk("t3_frame_err_hold", 32'(frame_err), 32'h1);
    send_byte(8'hC3, 1'b1);
    idle(4);
    chk("t3_next_data", 32'(cap_data[base+1]), 32'hC3);
    chk("t3_next_frame_err", 32'(cap_ferr[base+1]), 32'h0);

    // 4: back-to-back 0x00 / 0xFF with zero idle gap
    base = done_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(4);
    chk("t4_pulse_count", 32'(done_cnt - base), 32'd2);
    chk("t4_data0", 32'(cap_data[base]), 32'h00);
    chk("t4_ferr0", 32'(cap_ferr[base]), 32'h0);
    chk("t4_data1", 32'(cap_data[base+1]), 32'hFF);
    chk("t4_ferr1", 32'(cap_ferr[base+1]), 32'h0);

    // 5: reset during data bit 3 (line high there), then 0x81
    base = done_cnt;
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      repeat (16) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t5_reset_data", 32'(rx_data), 32'h0);
    chk("t5_reset_frame_err", 32'(frame_err), 32'h0);
    idle(200);
    chk("t5_no_pulse", 32'(done_cnt - base), 32'd0);
    send_byte(8'h81, 1'b1);
    idle(4);
    chk("t5_pulse_count", 32'(done_cnt - base), 32'd1);
    chk("t5_data", 32'(cap_data[base]), 32'h81);

`ifdef UART_RX_PARITY_EN
    // 6: 0x0F has even bit count; parity bit 0 is good, 1 is an error
    base = done_cnt;
    send_bits({1'b0, 8'h0F}, 9, 1'b1);
    idle(4);
    send_bits({1'b1, 8'h0F}, 9, 1'b1);
    idle(4);
    chk("t6_pulse_count", 32'(done_cnt - base), 32'd2);
    chk("t6_perr_good", 32'(cap_perr[base]), 32'h0);
    chk("t6_perr_bad", 32'(cap_perr[base+1]), 32'h1);
    chk("t6_data", 32'(cap_data[base+1]), 32'h0F);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
